// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
// State encodings, grant vectors and default widths.
package riscv_mem_arbiter_pkg;

  localparam int RISCV_ADDR_WIDTH = 32;
  localparam int RISCV_WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    LAST_I = 1'b0,
    LAST_D = 1'b1
  } last_gnt_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_I    = 2'b01;
  localparam logic [1:0] WIN_D    = 2'b10;

  function automatic logic [1:0] gnt_of(
    input arb_state_e s
  );
    logic [1:0] g;
    g = WIN_NONE;
    unique case (s)
      ARB_GNT_I: g = WIN_I;
      ARB_GNT_D: g = WIN_D;
      default:   g = WIN_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/riscv_mem_arbiter_pick.sv
// Combinational winner select for the memory arbiter.
// Fixed dmem priority with starvation override, or round-robin.
module mem_arb_pick
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int RR_MODE = 0
) (
  input  logic       imem_valid_i,
  input  logic       dmem_valid_i,
  input  last_gnt_e  last_gnt_i,
  input  logic       starve_i,
  output logic [1:0] win_o
);

  logic both;
  logic only_i;
  logic only_d;

  assign both   = imem_valid_i & dmem_valid_i;
  assign only_i = imem_valid_i & ~dmem_valid_i;
  assign only_d = dmem_valid_i & ~imem_valid_i;

  // One-hot winner; the two mode branches are exclusive by construction
  always_comb begin
    win_o = WIN_NONE;
    if (RR_MODE != 0) begin
      unique case (1'b1)
        both:    win_o = (last_gnt_i == LAST_D) ? WIN_I : WIN_D;
        only_i:  win_o = WIN_I;
        only_d:  win_o = WIN_D;
        default: win_o = WIN_NONE;
      endcase
    end else begin
      unique case (1'b1)
        dmem_valid_i && !(imem_valid_i && starve_i):
          win_o = WIN_D;
        imem_valid_i && (!dmem_valid_i || starve_i):
          win_o = WIN_I;
        default:
          win_o = WIN_NONE;
      endcase
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one valid/ready memory port between imem and dmem.
// Grant is held until the downstream ready pulse or an abort.
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = RISCV_ADDR_WIDTH,
  parameter int DATA_WIDTH = RISCV_WORD_WIDTH,
  parameter int RR_MODE    = 0,
  parameter int MAX_CONSEC = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  imem_valid_i,
  output logic                  imem_ready_o,
  input  logic [ADDR_WIDTH-1:0] imem_addr_i,
  input  logic [DATA_WIDTH-1:0] imem_wdata_i,
  input  logic [3:0]            imem_we_i,
  output logic [DATA_WIDTH-1:0] imem_rdata_o,
  input  logic                  dmem_valid_i,
  output logic                  dmem_ready_o,
  input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
  input  logic [3:0]            dmem_we_i,
  output logic [DATA_WIDTH-1:0] dmem_rdata_o,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_we_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [1:0]            grant_o
);

  localparam logic [3:0] MAX_C = MAX_CONSEC[3:0];

  arb_state_e state_q;
  arb_state_e state_d;
  logic [3:0] consec_q;
  logic [3:0] consec_d;
  last_gnt_e  last_q;
  last_gnt_e  last_d;
  logic [1:0] win;
  logic       starve;
  logic [3:0] consec_inc;

  assign starve     = (consec_q == MAX_C);
  assign consec_inc = starve ? consec_q : 4'(consec_q + 4'd1);

  mem_arb_pick #(
    .RR_MODE (RR_MODE)
  ) u_pick (
    .imem_valid_i (imem_valid_i),
    .dmem_valid_i (dmem_valid_i),
    .last_gnt_i   (last_q),
    .starve_i     (starve),
    .win_o        (win)
  );

  assign imem_rdata_o = mem_rdata_i;
  assign dmem_rdata_o = mem_rdata_i;
  assign grant_o      = gnt_of(state_q);

  // State, starvation counter and last-grant history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      consec_q <= 4'd0;
      last_q   <= LAST_D;
    end else begin
      state_q  <= state_d;
      consec_q <= consec_d;
      last_q   <= last_d;
    end
  end

  // Arbitration in IDLE, request mux and completion while granted
  always_comb begin
    state_d      = state_q;
    consec_d     = consec_q;
    last_d       = last_q;
    mem_valid_o  = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_we_o     = 4'd0;
    imem_ready_o = 1'b0;
    dmem_ready_o = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        unique case (1'b1)
          win[0]: begin
            state_d  = ARB_GNT_I;
            last_d   = LAST_I;
            consec_d = 4'd0;
          end
          win[1]: begin
            state_d  = ARB_GNT_D;
            last_d   = LAST_D;
            consec_d = imem_valid_i ? consec_inc : 4'd0;
          end
          default: state_d = ARB_IDLE;
        endcase
      end
      ARB_GNT_I: begin
        mem_valid_o  = imem_valid_i;
        mem_addr_o   = imem_addr_i;
        mem_wdata_o  = imem_wdata_i;
        mem_we_o     = imem_we_i;
        imem_ready_o = mem_ready_i;
        if (mem_ready_i || !imem_valid_i) begin
          state_d = ARB_IDLE;
        end
      end
      ARB_GNT_D: begin
        mem_valid_o  = dmem_valid_i;
        mem_addr_o   = dmem_addr_i;
        mem_wdata_o  = dmem_wdata_i;
        mem_we_o     = dmem_we_i;
        dmem_ready_o = mem_ready_i;
        if (mem_ready_i || !dmem_valid_i) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule
